// File: rtl/muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_iter_unit
//  Purpose  : Iterative RV32M/RV64M multiply/divide unit. Radix-2 datapath,
//             one bit per cycle, with valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] C_F3_MUL    = 3'b000;
  localparam logic [2:0] C_F3_MULH   = 3'b001;
  localparam logic [2:0] C_F3_MULHSU = 3'b010;
  localparam logic [2:0] C_F3_DIV    = 3'b100;
  localparam logic [2:0] C_F3_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           funct3_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 neg_q;       // result (quotient/product/remainder) needs negation
  logic [XLEN-1:0]      op_q;        // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]    acc_q;       // mul: {hi, multiplier}; div: {remainder, quotient}
  logic                 resp_valid_q;
  logic [XLEN-1:0]      resp_data_q;
  logic [TAG_W-1:0]     resp_tag_q;

  // --------------------------------------------------------------------------
  // Request decode and operand conditioning (used only in the accept cycle)
  // --------------------------------------------------------------------------
  logic              w_req_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_data;
  logic              w_neg_res;

  // Classify the incoming op, form magnitudes and detect divide special cases
  always_comb begin
    w_req_is_div = req_funct3[2];
    w_a_signed   = (req_funct3 == C_F3_MULH) || (req_funct3 == C_F3_MULHSU) ||
                   (req_funct3 == C_F3_DIV)  || (req_funct3 == C_F3_REM);
    w_b_signed   = (req_funct3 == C_F3_MULH) || (req_funct3 == C_F3_DIV) ||
                   (req_funct3 == C_F3_REM);
    w_neg_a      = w_a_signed & req_rs1[XLEN-1];
    w_neg_b      = w_b_signed & req_rs2[XLEN-1];
    // Negating INT_MIN yields INT_MIN, which is the correct unsigned magnitude.
    w_mag_a      = w_neg_a ? (~req_rs1 + 1'b1) : req_rs1;
    w_mag_b      = w_neg_b ? (~req_rs2 + 1'b1) : req_rs2;

    w_div_zero   = w_req_is_div && (req_rs2 == '0);
    w_div_ovf    = w_req_is_div && !req_funct3[0] &&
                   (req_rs1 == C_INT_MIN) && (req_rs2 == {XLEN{1'b1}});
    w_special    = w_div_zero || w_div_ovf;

    // funct3[1] distinguishes remainder ops from quotient ops.
    w_special_data = '0;
    if (w_div_zero) begin
      w_special_data = req_funct3[1] ? req_rs1 : {XLEN{1'b1}};
    end else if (w_div_ovf) begin
      w_special_data = req_funct3[1] ? '0 : req_rs1;
    end

    // Remainder follows the dividend's sign; quotient and product use the XOR.
    w_neg_res = (w_req_is_div && req_funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
  end

  // --------------------------------------------------------------------------
  // One radix-2 iteration of each datapath
  // --------------------------------------------------------------------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step_d;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_step_d;

  // Shift-add multiply step and restoring shift-subtract divide step
  always_comb begin
    // Add multiplicand into the upper half when the current multiplier bit is
    // set, then shift the whole accumulator right; the carry lands on top.
    w_mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
    w_mul_step_d = {w_mul_sum, acc_q[XLEN-1:1]};

    // Bring the next dividend bit into the partial remainder and try the
    // subtraction; a clear top bit of the difference means no borrow.
    w_div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    w_div_diff   = w_div_shift - {1'b0, op_q};
    w_div_ge     = ~w_div_diff[XLEN];
    w_div_rem    = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    w_div_step_d = {w_div_rem, acc_q[XLEN-2:0], w_div_ge};
  end

  // --------------------------------------------------------------------------
  // Sign fix-up and result selection
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_data_d;

  // Apply the latched sign to the raw magnitude result and pick the output word
  always_comb begin
    w_prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    w_quo      = acc_q[XLEN-1:0];
    w_rem      = acc_q[2*XLEN-1:XLEN];
    if (funct3_q[2]) begin
      if (funct3_q[1]) begin
        w_fix_data_d = neg_q ? (~w_rem + 1'b1) : w_rem;
      end else begin
        w_fix_data_d = neg_q ? (~w_quo + 1'b1) : w_quo;
      end
    end else if (funct3_q == C_F3_MUL) begin
      w_fix_data_d = w_prod_fix[XLEN-1:0];
    end else begin
      w_fix_data_d = w_prod_fix[2*XLEN-1:XLEN];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // --------------------------------------------------------------------------
  // Sequence accept, iterate, fix-up and response hold; flush aborts anything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      funct3_q     <= '0;
      tag_q        <= '0;
      neg_q        <= 1'b0;
      op_q         <= '0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            tag_q    <= req_tag;
            neg_q    <= w_neg_res;
            cnt_q    <= '0;
            if (w_req_is_div) begin
              op_q  <= w_mag_b;
              acc_q <= {{XLEN{1'b0}}, w_mag_a};
            end else begin
              op_q  <= w_mag_a;
              acc_q <= {{XLEN{1'b0}}, w_mag_b};
            end
            if (w_special) begin
              // Result is final now; valid is raised on the following edge.
              resp_data_q <= w_special_data;
              resp_tag_q  <= req_tag;
              state_q     <= S_DONE;
            end else begin
              state_q     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= funct3_q[2] ? w_div_step_d : w_mul_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          resp_data_q  <= w_fix_data_d;
          resp_tag_q   <= tag_q;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
          end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_iter_unit
//  Purpose  : Self-checking bench for muldiv_iter_unit (XLEN = 32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
  );

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t scb[$];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference using wide native arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv, p;
    logic [63:0] ua, ub, pu;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    model = '0;
    case (f3)
      3'd0: begin p = sa * sbv;          model = p[31:0];  end
      3'd1: begin p = sa * sbv;          model = p[63:32]; end
      3'd2: begin p = sa * $signed(ub);  model = p[63:32]; end
      3'd3: begin pu = ua * ub;          model = pu[63:32]; end
      3'd4: begin if (b == 0) model = '1; else begin p = sa / sbv; model = p[31:0]; end end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin if (b == 0) model = a; else begin p = sa % sbv; model = p[31:0]; end end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Present a request at posedge+1, let it be accepted, then scramble inputs.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    check("issue.req_ready", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_tag    = tag;
    @(posedge clk); #1;
    scb.push_back('{data: exp, tag: tag});
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    req_tag    = 5'($urandom);
  endtask

  // Count edges from accept to resp_valid and compare against the scoreboard.
  task automatic wait_resp(input string lbl, input int exp_lat,
                           output logic [31:0] ed, output logic [4:0] et);
    int n = 0;
    bit busy_ok = 1'b1;
    exp_t e;
    while (resp_valid !== 1'b1 && n < 200) begin
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({lbl, ".latency"}, 64'(n), 64'(exp_lat));
    check({lbl, ".busy_ready_low"}, busy_ok, 1'b1);
    check({lbl, ".done_ready_low"}, req_ready, 1'b0);
    ed = '0;
    et = '0;
    if (scb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s.scoreboard: got response 0x%0h, expected none", lbl, resp_data);
    end else begin
      e  = scb.pop_front();
      ed = e.data;
      et = e.tag;
      check({lbl, ".data"}, resp_data, ed);
      check({lbl, ".tag"}, resp_tag, et);
    end
  endtask

  // Complete the response transfer and confirm the unit is idle again.
  task automatic release_resp(input string lbl, input logic keep);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = keep;
    check({lbl, ".valid_after"}, resp_valid, 1'b0);
    check({lbl, ".ready_after"}, req_ready, 1'b1);
  endtask

  task automatic run_op(input string lbl, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                        input bit special);
    logic [31:0] ed;
    logic [4:0]  et;
    issue(f3, a, b, tag, exp);
    wait_resp(lbl, special ? 1 : XLEN + 1, ed, et);
    release_resp(lbl, resp_ready);
  endtask

  // Watch for any spurious response over a window of cycles.
  task automatic expect_quiet(input string lbl, input int cycles);
    bit seen = 1'b0;
    bit rdy  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
      if (req_ready !== 1'b1) rdy = 1'b0;
    end
    check({lbl, ".no_response"}, seen, 1'b0);
    check({lbl, ".stays_idle"}, rdy, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ed;
    logic [4:0]  et;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    tbl[0]  = '{f3: 3'd0, a: 32'd7,          b: 32'hFFFF_FFFD, tag: 5'd9,  exp: 32'hFFFF_FFEB, special: 1'b0};
    tbl[1]  = '{f3: 3'd1, a: 32'h8000_0000,  b: 32'h8000_0000, tag: 5'd1,  exp: 32'h4000_0000, special: 1'b0};
    tbl[2]  = '{f3: 3'd3, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF, tag: 5'd2,  exp: 32'hFFFF_FFFE, special: 1'b0};
    tbl[3]  = '{f3: 3'd2, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF, tag: 5'd3,  exp: 32'hFFFF_FFFF, special: 1'b0};
    tbl[4]  = '{f3: 3'd4, a: 32'hFFFF_FFF9,  b: 32'd2,         tag: 5'd4,  exp: 32'hFFFF_FFFD, special: 1'b0};
    tbl[5]  = '{f3: 3'd6, a: 32'hFFFF_FFF9,  b: 32'd2,         tag: 5'd5,  exp: 32'hFFFF_FFFF, special: 1'b0};
    tbl[6]  = '{f3: 3'd5, a: 32'd7,          b: 32'd2,         tag: 5'd6,  exp: 32'd3,         special: 1'b0};
    tbl[7]  = '{f3: 3'd7, a: 32'hFFFF_FFFF,  b: 32'h10,        tag: 5'd7,  exp: 32'hF,         special: 1'b0};
    tbl[8]  = '{f3: 3'd4, a: 32'd5,          b: 32'd0,         tag: 5'd8,  exp: 32'hFFFF_FFFF, special: 1'b1};
    tbl[9]  = '{f3: 3'd7, a: 32'd5,          b: 32'd0,         tag: 5'd10, exp: 32'd5,         special: 1'b1};
    tbl[10] = '{f3: 3'd4, a: 32'h8000_0000,  b: 32'hFFFF_FFFF, tag: 5'd11, exp: 32'h8000_0000, special: 1'b1};
    tbl[11] = '{f3: 3'd6, a: 32'h8000_0000,  b: 32'hFFFF_FFFF, tag: 5'd12, exp: 32'd0,         special: 1'b1};
    tbl[12] = '{f3: 3'd5, a: 32'd5,          b: 32'd0,         tag: 5'd13, exp: 32'hFFFF_FFFF, special: 1'b1};
    tbl[13] = '{f3: 3'd6, a: 32'd5,          b: 32'd0,         tag: 5'd14, exp: 32'd5,         special: 1'b1};
    tbl[14] = '{f3: 3'd4, a: 32'd7,          b: 32'hFFFF_FFFE, tag: 5'd15, exp: 32'hFFFF_FFFD, special: 1'b0};
    tbl[15] = '{f3: 3'd6, a: 32'd7,          b: 32'hFFFF_FFFE, tag: 5'd16, exp: 32'd1,         special: 1'b0};
    tbl[16] = '{f3: 3'd3, a: 32'h0001_0000,  b: 32'h0001_0000, tag: 5'd17, exp: 32'd1,         special: 1'b0};
    tbl[17] = '{f3: 3'd7, a: 32'd100,        b: 32'd7,         tag: 5'd31, exp: 32'd2,         special: 1'b0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_tag    = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.req_ready", req_ready, 1'b1);
    check("reset.resp_valid", resp_valid, 1'b0);
    check("reset.resp_data", resp_data, 32'd0);
    check("reset.resp_tag", resp_tag, 5'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table with the consumer always ready.
    resp_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].tag,
             tbl[i].exp, tbl[i].special);
    end

    // Random operands against the reference model.
    for (int i = 0; i < 16; i++) begin
      rf3 = 3'($urandom);
      ra  = $urandom;
      rb  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op($sformatf("rnd%0d", i), rf3, ra, rb, 5'(i), model(rf3, ra, rb),
             is_special(rf3, ra, rb));
    end

    // Backpressure: hold the result for 10 cycles, then a back-to-back issue.
    resp_ready = 1'b0;
    issue(3'd0, 32'h0000_1234, 32'h0000_0100, 5'd21, 32'h0012_3400);
    wait_resp("bp", XLEN + 1, ed, et);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d.valid", i), resp_valid, 1'b1);
      check($sformatf("bp.hold%0d.data", i), resp_data, ed);
      check($sformatf("bp.hold%0d.tag", i), resp_tag, et);
      check($sformatf("bp.hold%0d.ready", i), req_ready, 1'b0);
    end
    release_resp("bp", 1'b0);
    issue(3'd5, 32'd1000, 32'd7, 5'd22, 32'd142);
    check("bp.b2b_accepted", req_ready, 1'b0);
    wait_resp("bp.b2b", XLEN + 1, ed, et);
    release_resp("bp.b2b", 1'b0);

    // Flush at CALC iteration 10 together with a new request.
    issue(3'd5, 32'd1000, 32'd7, 5'd23, 32'd142);
    repeat (10) @(posedge clk);
    #1;
    flush      = 1'b1;
    req_valid  = 1'b1;
    req_funct3 = 3'd0;
    req_rs1    = 32'd3;
    req_rs2    = 32'd3;
    req_tag    = 5'd24;
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_calc.req_ready", req_ready, 1'b1);
    check("flush_calc.resp_valid", resp_valid, 1'b0);
    scb.delete();
    resp_ready = 1'b1;
    expect_quiet("flush_calc", 45);

    // Flush in IDLE coincident with a request: the request must not be taken.
    req_valid  = 1'b1;
    req_funct3 = 3'd0;
    req_rs1    = 32'd5;
    req_rs2    = 32'd6;
    req_tag    = 5'd25;
    flush      = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle.req_ready", req_ready, 1'b1);
    expect_quiet("flush_idle", 40);
    run_op("after_flush", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd26, 32'hFFFF_FFF2, 1'b0);

    // Asynchronous reset pulse mid-CALC, between clock edges.
    issue(3'd0, 32'd11, 32'd13, 5'd27, 32'd143);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.resp_valid", resp_valid, 1'b0);
    check("async_rst.resp_data", resp_data, 32'd0);
    check("async_rst.resp_tag", resp_tag, 5'd0);
    check("async_rst.req_ready", req_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    scb.delete();
    expect_quiet("async_rst", 40);
    run_op("after_rst", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd28, 32'hFFFF_FFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_iter_unit.md
# muldiv_iter_unit

Iterative, parametrised RV32M/RV64M multiply/divide execution unit. It is the sequential successor to the combinational ALU control path. The decode stage routes any `Funct7 == 7'b0000001` R-type op here instead of to the single-cycle ALU. Funct3 selects one of eight M-extension operations, and a valid/ready handshake on each side lets the pipeline stall while the radix-2 datapath runs one bit per cycle.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width (32 or 64).
- `TAG_W`, default 5: width of the destination-register tag carried with each request.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; equals (state == IDLE).
- `req_funct3` in 3: op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_rs1` in XLEN: operand A (dividend or multiplicand).
- `req_rs2` in XLEN: operand B (divisor or multiplier).
- `req_tag` in TAG_W: destination tag, echoed on the response.
- `flush` in 1: synchronous kill of any in-flight op.
- `resp_valid` out 1: result held.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out XLEN: result.
- `resp_tag` out TAG_W: tag of the result.

## Operation

- States are IDLE, CALC, FIX and DONE.
- **IDLE.** When `req_valid && !flush`:
  - Latch funct3, tag and operand signs.
  - Latch magnitudes: an operand is treated as signed for MULH (both), MULHSU (rs1 only) and DIV/REM (both). All others are unsigned.
  - Clear the iteration counter.
  - Go to CALC.
  - Special cases go straight to DONE with the result formed in the accept cycle:
    - Divide-by-zero: DIV/DIVU give all-ones; REM/REMU give rs1.
    - Signed overflow (DIV/REM with rs1 = 2^(XLEN-1) and rs2 = all-ones): DIV gives rs1; REM gives 0.
- **CALC.** Performs exactly XLEN iterations on the magnitudes, then goes to FIX.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract; XLEN-bit remainder, XLEN-bit quotient.
- **FIX.**
  - Multiply: negate the product if (signA ^ signB); MUL takes bits [XLEN-1:0], MULH/MULHSU/MULHU take bits [2·XLEN-1:XLEN].
  - Divide: negate the quotient if (signA ^ signB) for DIV; negate the remainder if signA for REM.
  - Register `resp_data` and `resp_tag`, then go to DONE.
- **DONE.**
  - `resp_valid` = 1.
  - `resp_data` and `resp_tag` stay stable until `resp_ready`, then the unit returns to IDLE.
  - No new request is accepted in DONE.
- **flush.**
  - From any state, the unit goes to IDLE at the next edge and `resp_valid` is 0 from that edge.
  - flush has priority over a simultaneous accept or `resp_ready`; the request is not taken.
- **Reset.** `rst_n` low forces IDLE immediately, whether idle or mid-operation:
  - `resp_valid` = 0, `resp_data` = 0, `resp_tag` = 0, counter = 0.
  - `req_ready` = 1.
- **Widths.** All arithmetic is modulo 2^XLEN or 2^(2·XLEN). Negation is two's complement. The magnitude of 2^(XLEN-1) is representable unsigned. The counter is $clog2(XLEN)+1 bits.

## Timing

- Accept happens at the edge where `req_valid && req_ready && !flush`.
- Normal ops: CALC occupies XLEN cycles and FIX 1 cycle. `resp_valid` rises XLEN+1 edges after the accept edge, which is XLEN+2 cycles after the request is presented (34 for XLEN = 32).
- Special-case divides: `resp_valid` rises at the edge after accept (1-cycle latency).
- Response transfer happens at the edge where `resp_valid && resp_ready`. `req_ready` rises at that edge, so the minimum issue interval is latency + 1 cycle.
- `req_ready` is purely a function of state: no combinational path from `req_valid` or `resp_ready`.
- Inputs are sampled only at accept. Changes to `req_*` afterwards have no effect.

## Test plan

- **Multiply.** MUL rs1 = 7, rs2 = 0xFFFFFFFD, tag 9 (XLEN = 32) → `resp_data` 0xFFFFFFEB, `resp_tag` 9, `resp_valid` first high exactly 34 cycles after presentation, `req_ready` low throughout.
- **High multiplies.** Each with `resp_ready` tied 1:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed and unsigned divide.**
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 7 / 2 → 3.
  - REMU 0xFFFFFFFF / 0x10 → 0xF.
- **Special cases.** Each gives `resp_valid` 1 cycle after accept:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Backpressure.** Hold `resp_ready` = 0 for 10 cycles in DONE → `resp_valid`, `resp_data` and `resp_tag` stable and `req_ready` = 0. Then raise `resp_ready` for 1 cycle → IDLE, `req_ready` = 1 the next cycle, and a back-to-back request is accepted.
- **Flush and reset.**
  - Assert flush at CALC iteration 10 together with `req_valid` → no response ever produced, `req_ready` = 1 after the edge, the coincident request is not accepted, and the next request still computes correctly.
  - Pulse `rst_n` low mid-CALC, between clock edges → outputs zero and IDLE immediately.
